// File: rtl/game_ctl_timed.sv
// ---------------------------------------------------------------------------
// game_ctl_timed
//
// Game-flow controller for the two-player duck game.  The four screens are
// IDLE -> WAIT -> GAME -> SCORE.  WAIT, GAME and SCORE are timed in video
// frames by one shared down-counter, so each round lasts a fixed number of
// frames whatever the pixel clock rate is.
//
// The controller sits between the input side (mouse clicks, UART handshake)
// and the VGA layer mux.  Its `state` output selects which screen is drawn.
//
// Parameters
//   GAME_FRAMES   frames a round lasts; must be >= 1 and < 2**TIMER_W
//   WAIT_FRAMES   frames WAIT waits for the opponent before giving up
//   SCORE_FRAMES  frames the SCORE screen is shown before returning to IDLE
//   SCORE_W       hit counter width; the counter saturates at 2**SCORE_W-1
//   TIMER_W       width of the shared frame down-counter
//
// Ports
//   pclk          in   pixel clock; every register updates on its rising edge
//   rst           in   synchronous reset, active low
//   vsync         in   VGA vsync; each rising edge is one frame tick
//   play_clicked  in   1-cycle pulse, local player clicked PLAY
//   remote_ready  in   level, the opponent is ready (from UART)
//   duck_hit      in   1-cycle pulse, a duck was hit this cycle
//   abort         in   level, abort the current round (right mouse button)
//   state         out  00 IDLE, 01 WAIT, 10 GAME, 11 SCORE
//   local_ready   out  high while in WAIT; our ready flag for the UART
//   score         out  hits in the current or last round
//   frames_left   out  frames left in the current timed state; 0 in IDLE
//   game_over     out  1-cycle pulse on the GAME -> SCORE transition
//
// All outputs are registered.  When a transition condition is sampled at
// clock edge N, the new values are on the outputs right after edge N.
// ---------------------------------------------------------------------------
module game_ctl_timed #(
  parameter int GAME_FRAMES  = 1800,
  parameter int WAIT_FRAMES  = 600,
  parameter int SCORE_FRAMES = 300,
  parameter int SCORE_W      = 7,
  parameter int TIMER_W      = 12
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               play_clicked,
  input  logic               remote_ready,
  input  logic               duck_hit,
  input  logic               abort,
  output logic [1:0]         state,
  output logic               local_ready,
  output logic [SCORE_W-1:0] score,
  output logic [TIMER_W-1:0] frames_left,
  output logic               game_over
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_GAME  = 2'b10,
    ST_SCORE = 2'b11
  } state_t;

  localparam logic [TIMER_W-1:0] WAIT_LOAD  = TIMER_W'(WAIT_FRAMES);
  localparam logic [TIMER_W-1:0] GAME_LOAD  = TIMER_W'(GAME_FRAMES);
  localparam logic [TIMER_W-1:0] SCORE_LOAD = TIMER_W'(SCORE_FRAMES);
  localparam logic [TIMER_W-1:0] FRAME_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] FRAME_ZERO = '0;
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  state_t             state_reg;
  logic               local_ready_reg;
  logic [SCORE_W-1:0] score_reg;
  logic [TIMER_W-1:0] frames_reg;
  logic               game_over_reg;
  logic               vsync_q;

  logic               tick;
  logic               last_frame;
  logic [SCORE_W-1:0] score_hit;
  logic [TIMER_W-1:0] frames_dec;

  // Frame tick: high for the single cycle in which vsync is already high but
  // its registered copy is still low.
  assign tick = vsync & ~vsync_q;

  // The counter is compared against "at most one" rather than "exactly one"
  // so that a zero count can never decrement and wrap around.
  assign last_frame = (frames_reg <= FRAME_ONE);
  assign frames_dec = last_frame ? FRAME_ZERO : (frames_reg - FRAME_ONE);

  // Saturating hit counter.  The hit is counted even in the cycle that ends
  // the round, so GAME always takes score_hit, including on its way out.
  always_comb begin
    score_hit = score_reg;
    if (duck_hit && (score_reg != SCORE_MAX)) begin
      score_hit = score_reg + SCORE_ONE;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      local_ready_reg <= 1'b0;
      score_reg       <= '0;
      frames_reg      <= '0;
      game_over_reg   <= 1'b0;
      vsync_q         <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      game_over_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          local_ready_reg <= 1'b0;
          frames_reg      <= FRAME_ZERO;
          if (play_clicked) begin
            state_reg       <= ST_WAIT;
            local_ready_reg <= 1'b1;
            frames_reg      <= WAIT_LOAD;
          end
        end

        // Opponent readiness wins over a local abort, and both win over the
        // timeout, so a late but simultaneous handshake still starts a game.
        ST_WAIT: begin
          if (remote_ready) begin
            state_reg       <= ST_GAME;
            local_ready_reg <= 1'b0;
            score_reg       <= '0;
            frames_reg      <= GAME_LOAD;
          end else if (abort) begin
            state_reg       <= ST_IDLE;
            local_ready_reg <= 1'b0;
            frames_reg      <= FRAME_ZERO;
          end else if (tick) begin
            frames_reg <= frames_dec;
            if (last_frame) begin
              state_reg       <= ST_IDLE;
              local_ready_reg <= 1'b0;
            end
          end
        end

        ST_GAME: begin
          score_reg <= score_hit;
          if (abort || (tick && last_frame)) begin
            state_reg     <= ST_SCORE;
            frames_reg    <= SCORE_LOAD;
            game_over_reg <= 1'b1;
          end else if (tick) begin
            frames_reg <= frames_dec;
          end
        end

        // Score is frozen here; play_clicked and duck_hit have no effect.
        ST_SCORE: begin
          if (abort) begin
            state_reg  <= ST_IDLE;
            frames_reg <= FRAME_ZERO;
          end else if (tick) begin
            frames_reg <= frames_dec;
            if (last_frame) begin
              state_reg <= ST_IDLE;
            end
          end
        end

        default: begin
          state_reg       <= ST_IDLE;
          local_ready_reg <= 1'b0;
          frames_reg      <= FRAME_ZERO;
        end
      endcase
    end
  end

  assign state       = state_reg;
  assign local_ready = local_ready_reg;
  assign score       = score_reg;
  assign frames_left = frames_reg;
  assign game_over   = game_over_reg;

endmodule

// File: tb/tb_game_ctl_timed.sv
// ---------------------------------------------------------------------------
// tb_game_ctl_timed
//
// Self-checking bench for game_ctl_timed with short timings
// (WAIT=3, GAME=4, SCORE=5 frames, 3-bit score, 8-bit timer).
//
// Each scenario is a table of rows: the inputs for one clock cycle and the
// outputs required right after that cycle's rising edge.  The required value
// is pushed to a scoreboard queue when the inputs are driven.  It is popped
// and compared once the edge has produced the DUT outputs.
// Packed output order: {state, local_ready, score, frames_left, game_over}.
// ---------------------------------------------------------------------------
module tb_game_ctl_timed;

  localparam int GAME_FRAMES  = 4;
  localparam int WAIT_FRAMES  = 3;
  localparam int SCORE_FRAMES = 5;
  localparam int SCORE_W      = 3;
  localparam int TIMER_W      = 8;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] WAIT  = 2'b01;
  localparam logic [1:0] GAME  = 2'b10;
  localparam logic [1:0] SCORE = 2'b11;

  logic               pclk;
  logic               rst;
  logic               vsync;
  logic               play_clicked;
  logic               remote_ready;
  logic               duck_hit;
  logic               abort;
  logic [1:0]         state;
  logic               local_ready;
  logic [SCORE_W-1:0] score;
  logic [TIMER_W-1:0] frames_left;
  logic               game_over;

  logic [14:0] sb[$];
  int          checks = 0;
  int          passes = 0;

  game_ctl_timed #(
    .GAME_FRAMES (GAME_FRAMES),
    .WAIT_FRAMES (WAIT_FRAMES),
    .SCORE_FRAMES(SCORE_FRAMES),
    .SCORE_W     (SCORE_W),
    .TIMER_W     (TIMER_W)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .vsync       (vsync),
    .play_clicked(play_clicked),
    .remote_ready(remote_ready),
    .duck_hit    (duck_hit),
    .abort       (abort),
    .state       (state),
    .local_ready (local_ready),
    .score       (score),
    .frames_left (frames_left),
    .game_over   (game_over)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Input row: {rst, play_clicked, remote_ready, duck_hit, abort, vsync}
  function automatic logic [5:0] in_row(input logic r, input logic pc,
                                        input logic rr, input logic dh,
                                        input logic ab, input logic vs);
    return {r, pc, rr, dh, ab, vs};
  endfunction

  function automatic logic [14:0] out_row(input logic [1:0] st, input logic lr,
                                          input int sc, input int fl,
                                          input logic go);
    logic [SCORE_W-1:0] sc_v;
    logic [TIMER_W-1:0] fl_v;
    sc_v = SCORE_W'(sc);
    fl_v = TIMER_W'(fl);
    return {st, lr, sc_v, fl_v, go};
  endfunction

  // Drive one row's inputs mid-cycle and register its expectation.
  task automatic drive_row(input logic [20:0] row);
    @(negedge pclk);
    {rst, play_clicked, remote_ready, duck_hit, abort, vsync} = row[20:15];
    sb.push_back(row[14:0]);
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] rows[$];
    logic [14:0] obs;
    logic [14:0] req;
    rows.push_back({in_row(0,0,0,0,0,0), out_row(IDLE,0,0,0,0)});
    rows.push_back({in_row(0,1,0,0,0,0), out_row(IDLE,0,0,0,0)});
    rows.push_back({in_row(1,0,0,0,0,0), out_row(IDLE,0,0,0,0)});
    rows.push_back({in_row(1,0,1,1,1,1), out_row(IDLE,0,0,0,0)});
    foreach (rows[i]) begin
      drive_row(rows[i]);
      obs = {state, local_ready, score, frames_left, game_over};
      req = sb.pop_front();
      checks++;
      if (obs !== req) $display("FAIL reset[%0d] got %h required %h", i, obs, req);
      else passes++;
    end
  endtask

  task automatic test_handshake();
    logic [20:0] rows[$];
    logic [14:0] obs;
    logic [14:0] req;
    rows.push_back({in_row(1,1,0,0,0,0), out_row(WAIT,1,0,3,0)});
    rows.push_back({in_row(1,0,0,0,0,0), out_row(WAIT,1,0,3,0)});
    rows.push_back({in_row(1,0,1,0,0,0), out_row(GAME,0,0,4,0)});
    rows.push_back({in_row(1,1,1,0,0,0), out_row(GAME,0,0,4,0)});
    rows.push_back({in_row(1,0,0,0,1,0), out_row(SCORE,0,0,5,1)});
    rows.push_back({in_row(1,0,0,0,0,0), out_row(SCORE,0,0,5,0)});
    rows.push_back({in_row(1,0,0,0,1,0), out_row(IDLE,0,0,0,0)});
    rows.push_back({in_row(1,0,1,0,0,0), out_row(IDLE,0,0,0,0)});
    foreach (rows[i]) begin
      drive_row(rows[i]);
      obs = {state, local_ready, score, frames_left, game_over};
      req = sb.pop_front();
      checks++;
      if (obs !== req) $display("FAIL handshake[%0d] got %h required %h", i, obs, req);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    logic [20:0] rows[$];
    logic [14:0] obs;
    logic [14:0] req;
    rows.push_back({in_row(1,1,0,0,0,0), out_row(WAIT,1,0,3,0)});
    rows.push_back({in_row(1,0,0,0,0,1), out_row(WAIT,1,0,2,0)});
    rows.push_back({in_row(1,0,0,0,0,1), out_row(WAIT,1,0,2,0)});  // held high: no tick
    rows.push_back({in_row(1,0,0,0,0,0), out_row(WAIT,1,0,2,0)});
    rows.push_back({in_row(1,0,0,0,0,1), out_row(WAIT,1,0,1,0)});
    rows.push_back({in_row(1,0,0,0,0,0), out_row(WAIT,1,0,1,0)});
    rows.push_back({in_row(1,0,0,0,0,1), out_row(IDLE,0,0,0,0)});
    rows.push_back({in_row(1,0,0,0,0,0), out_row(IDLE,0,0,0,0)});
    foreach (rows[i]) begin
      drive_row(rows[i]);
      obs = {state, local_ready, score, frames_left, game_over};
      req = sb.pop_front();
      checks++;
      if (obs !== req) $display("FAIL timeout[%0d] got %h required %h", i, obs, req);
      else passes++;
    end
  endtask

  task automatic test_round();
    logic [20:0] rows[$];
    logic [14:0] obs;
    logic [14:0] req;
    rows.push_back({in_row(1,1,0,0,0,0), out_row(WAIT,1,0,3,0)});
    rows.push_back({in_row(1,0,1,0,0,0), out_row(GAME,0,0,4,0)});
    rows.push_back({in_row(1,0,0,1,0,0), out_row(GAME,0,1,4,0)});
    rows.push_back({in_row(1,0,0,1,0,1), out_row(GAME,0,2,3,0)});
    rows.push_back({in_row(1,0,0,1,0,0), out_row(GAME,0,3,3,0)});
    rows.push_back({in_row(1,0,0,0,0,1), out_row(GAME,0,3,2,0)});
    rows.push_back({in_row(1,0,0,1,0,0), out_row(GAME,0,4,2,0)});
    rows.push_back({in_row(1,0,0,0,0,1), out_row(GAME,0,4,1,0)});
    rows.push_back({in_row(1,0,0,0,0,0), out_row(GAME,0,4,1,0)});
    rows.push_back({in_row(1,0,0,1,0,1), out_row(SCORE,0,5,5,1)});  // hit on final tick
    rows.push_back({in_row(1,0,0,0,0,0), out_row(SCORE,0,5,5,0)});
    rows.push_back({in_row(1,0,0,1,0,0), out_row(SCORE,0,5,5,0)});  // score frozen
    rows.push_back({in_row(1,1,0,0,0,0), out_row(SCORE,0,5,5,0)});  // play ignored
    for (int f = 4; f >= 1; f--) begin
      rows.push_back({in_row(1,0,0,0,0,1), out_row(SCORE,0,5,f,0)});
      rows.push_back({in_row(1,0,0,0,0,0), out_row(SCORE,0,5,f,0)});
    end
    rows.push_back({in_row(1,0,0,0,0,1), out_row(IDLE,0,5,0,0)});
    rows.push_back({in_row(1,0,0,1,0,0), out_row(IDLE,0,5,0,0)});   // score kept
    foreach (rows[i]) begin
      drive_row(rows[i]);
      obs = {state, local_ready, score, frames_left, game_over};
      req = sb.pop_front();
      checks++;
      if (obs !== req) $display("FAIL round[%0d] got %h required %h", i, obs, req);
      else passes++;
    end
  endtask

  task automatic test_saturation();
    logic [20:0] rows[$];
    logic [14:0] obs;
    logic [14:0] req;
    rows.push_back({in_row(1,1,0,0,0,0), out_row(WAIT,1,5,3,0)});   // old score shown
    rows.push_back({in_row(1,0,1,0,0,0), out_row(GAME,0,0,4,0)});
    for (int h = 1; h <= 6; h++)
      rows.push_back({in_row(1,0,0,1,0,0), out_row(GAME,0,h,4,0)});
    rows.push_back({in_row(1,0,0,1,0,1), out_row(GAME,0,7,3,0)});
    for (int h = 0; h < 3; h++)
      rows.push_back({in_row(1,0,0,1,0,0), out_row(GAME,0,7,3,0)});
    rows.push_back({in_row(1,0,0,1,1,0), out_row(SCORE,0,7,5,1)});
    rows.push_back({in_row(1,0,0,0,1,0), out_row(IDLE,0,7,0,0)});
    rows.push_back({in_row(1,0,0,0,0,0), out_row(IDLE,0,7,0,0)});
    foreach (rows[i]) begin
      drive_row(rows[i]);
      obs = {state, local_ready, score, frames_left, game_over};
      req = sb.pop_front();
      checks++;
      if (obs !== req) $display("FAIL saturation[%0d] got %h required %h", i, obs, req);
      else passes++;
    end
  endtask

  task automatic test_abort();
    logic [20:0] rows[$];
    logic [14:0] obs;
    logic [14:0] req;
    rows.push_back({in_row(1,1,0,0,0,0), out_row(WAIT,1,7,3,0)});
    rows.push_back({in_row(1,0,1,0,0,0), out_row(GAME,0,0,4,0)});
    rows.push_back({in_row(1,0,0,1,0,0), out_row(GAME,0,1,4,0)});
    rows.push_back({in_row(1,0,0,0,0,1), out_row(GAME,0,1,3,0)});
    rows.push_back({in_row(1,0,0,0,0,0), out_row(GAME,0,1,3,0)});
    rows.push_back({in_row(1,0,0,0,0,1), out_row(GAME,0,1,2,0)});
    rows.push_back({in_row(1,0,0,1,0,0), out_row(GAME,0,2,2,0)});
    rows.push_back({in_row(1,0,0,0,1,0), out_row(SCORE,0,2,5,1)});
    rows.push_back({in_row(1,0,0,0,0,0), out_row(SCORE,0,2,5,0)});
    rows.push_back({in_row(1,0,0,0,1,0), out_row(IDLE,0,2,0,0)});
    rows.push_back({in_row(1,1,0,0,0,0), out_row(WAIT,1,2,3,0)});
    rows.push_back({in_row(1,0,0,0,1,1), out_row(IDLE,0,2,0,0)});   // abort in WAIT
    rows.push_back({in_row(1,0,0,0,0,0), out_row(IDLE,0,2,0,0)});
    foreach (rows[i]) begin
      drive_row(rows[i]);
      obs = {state, local_ready, score, frames_left, game_over};
      req = sb.pop_front();
      checks++;
      if (obs !== req) $display("FAIL abort[%0d] got %h required %h", i, obs, req);
      else passes++;
    end
  endtask

  task automatic test_priority();
    logic [20:0] rows[$];
    logic [14:0] obs;
    logic [14:0] req;
    rows.push_back({in_row(1,1,0,0,0,0), out_row(WAIT,1,2,3,0)});
    rows.push_back({in_row(1,0,0,0,0,1), out_row(WAIT,1,2,2,0)});
    rows.push_back({in_row(1,0,0,0,0,0), out_row(WAIT,1,2,2,0)});
    rows.push_back({in_row(1,0,0,0,0,1), out_row(WAIT,1,2,1,0)});
    rows.push_back({in_row(1,0,0,0,0,0), out_row(WAIT,1,2,1,0)});
    // remote_ready beats abort and the expiring timeout in the same cycle
    rows.push_back({in_row(1,0,1,0,1,1), out_row(GAME,0,0,4,0)});
    rows.push_back({in_row(1,0,1,0,1,0), out_row(SCORE,0,0,5,1)});
    rows.push_back({in_row(1,0,0,0,1,0), out_row(IDLE,0,0,0,0)});
    foreach (rows[i]) begin
      drive_row(rows[i]);
      obs = {state, local_ready, score, frames_left, game_over};
      req = sb.pop_front();
      checks++;
      if (obs !== req) $display("FAIL priority[%0d] got %h required %h", i, obs, req);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_game();
    logic [20:0] rows[$];
    logic [14:0] obs;
    logic [14:0] req;
    rows.push_back({in_row(1,1,0,0,0,0), out_row(WAIT,1,0,3,0)});
    rows.push_back({in_row(1,0,1,0,0,0), out_row(GAME,0,0,4,0)});
    for (int h = 1; h <= 5; h++)
      rows.push_back({in_row(1,0,0,1,0,0), out_row(GAME,0,h,4,0)});
    rows.push_back({in_row(0,0,0,1,0,0), out_row(IDLE,0,0,0,0)});
    rows.push_back({in_row(0,1,0,0,0,0), out_row(IDLE,0,0,0,0)});
    rows.push_back({in_row(0,0,1,0,1,1), out_row(IDLE,0,0,0,0)});
    rows.push_back({in_row(1,1,0,0,0,1), out_row(WAIT,1,0,3,0)});
    rows.push_back({in_row(1,0,0,0,0,1), out_row(WAIT,1,0,3,0)});
    rows.push_back({in_row(1,0,0,0,1,0), out_row(IDLE,0,0,0,0)});
    foreach (rows[i]) begin
      drive_row(rows[i]);
      obs = {state, local_ready, score, frames_left, game_over};
      req = sb.pop_front();
      checks++;
      if (obs !== req) $display("FAIL reset_mid_game[%0d] got %h required %h", i, obs, req);
      else passes++;
    end
  endtask

  initial begin
    rst          = 1'b0;
    vsync        = 1'b0;
    play_clicked = 1'b0;
    remote_ready = 1'b0;
    duck_hit     = 1'b0;
    abort        = 1'b0;
    test_reset();
    test_handshake();
    test_timeout();
    test_round();
    test_saturation();
    test_abort();
    test_priority();
    test_reset_mid_game();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d/%0d done", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
